mtr_drv: RTL

MTR_DRV -- requirements
Module: mtr_drv

---
 rtl/mtr_drv_pkg.sv | 21 ++
 rtl/mtr_drv_pwm_nonoverlap.sv | 62 ++++++
 rtl/mtr_drv.sv | 54 +++++
 3 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared widths, constants and helpers for the two-wheel H-bridge PWM driver.
// Imported by mtr_drv and its pwm_nonoverlap leg generator.
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam int DT_W  = 8;

    localparam logic [PWM_W-1:0] PERIOD_MAX  = 11'h7FF;
    localparam logic [PWM_W-1:0] DUTY_OFFSET = 11'h400;

    localparam int DEADTIME_DEF = 32;

    typedef logic [PWM_W-1:0]        pwm_cnt_t;
    typedef logic signed [PWM_W-1:0] spd_t;

    // Signed speed to offset-binary duty: inverting the sign bit is the same as adding 0x400.
    function automatic pwm_cnt_t spd_to_duty(input spd_t spd);
        return {~spd[PWM_W-1], spd[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_nonoverlap.sv
// One H-bridge side: period-latched duty compare followed by a dead-time filter
// that only lets a leg assert after the compare has been stable for DEADTIME clks.
module pwm_nonoverlap
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  pwm_cnt_t cnt,
    input  spd_t     spd,
    output logic     pwm1,
    output logic     pwm2
);

    localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEADTIME);

    pwm_cnt_t        duty_q;
    logic            raw;
    logic            raw_q;
    logic [DT_W-1:0] dt_cnt;
    logic            dt_done;

    // Duty is only sampled on the last count so a period never sees a mid-period speed change.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_OFFSET;
        end else if (cnt == PERIOD_MAX) begin
            duty_q <= spd_to_duty(spd);
        end
    end

    assign raw     = (cnt < duty_q);
    assign dt_done = (dt_cnt == DT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q  <= 1'b0;
            dt_cnt <= '0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                dt_cnt <= '0;
            end else if (!dt_done) begin
                dt_cnt <= dt_cnt + 1'b1;
            end
        end
    end

    // Both legs share dt_done and take opposite polarities of raw_q, so they can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm1 <= 1'b0;
            pwm2 <= 1'b0;
        end else begin
            pwm1 <= raw_q & dt_done;
            pwm2 <= ~raw_q & dt_done;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual-wheel motor PWM driver: one shared 2048-clk period counter feeding two
// independent non-overlapping H-bridge leg generators, plus a period-start pulse.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PWM_W-1:0]   lft_spd,
    input  logic [PWM_W-1:0]   rght_spd,
    output logic               lftPWM1,
    output logic               lftPWM2,
    output logic               rghtPWM1,
    output logic               rghtPWM2,
    output logic               period_strt
);

    pwm_cnt_t cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt also rests at zero during reset, so the pulse is qualified by rst_n to stay low there.
    assign period_strt = rst_n & (cnt == '0);

    pwm_nonoverlap #(
        .DEADTIME (DEADTIME)
    ) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (spd_t'(lft_spd)),
        .pwm1  (lftPWM1),
        .pwm2  (lftPWM2)
    );

    pwm_nonoverlap #(
        .DEADTIME (DEADTIME)
    ) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (spd_t'(rght_spd)),
        .pwm1  (rghtPWM1),
        .pwm2  (rghtPWM2)
    );

endmodule
